// File: rtl/timebase_gen.sv
`default_nettype none
// ============================================================================
// Module      : timebase_gen
// Description : Programmable timebase. A prescaler divides clk by the
//               active period P (P=0 behaves as P=1) and produces a tick.
//               Each tick advances an elapsed-time counter. NCH compare
//               channels pulse when the new time value matches their
//               compare value. An optional snapshot unit captures the
//               time and prescaler values on request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Configuration macro:
//   TIMEBASE_SNAPSHOT_EN - when defined, snapshot capture logic is built.
//                          When undefined, the snapshot outputs are tied to
//                          0 and snap_req is ignored.
// Ports:
//   clk        in   1              sole clock, rising edge
//   rst        in   1              asynchronous reset, active low
//   en         in   1              count enable (low freezes prescaler/time)
//   clear      in   1              synchronous clear of prescaler and time
//   period     in   PRESC_W        clocks per tick
//   cmp_val    in   NCH*TIME_W     compare values, ch i at [i*TIME_W +: TIME_W]
//   cmp_en     in   NCH            per-channel compare enable
//   snap_req   in   1              snapshot strobe
//   time_o     out  TIME_W         elapsed tick count
//   tick       out  1              one-cycle pulse per tick
//   wrap       out  1              one-cycle pulse when time_o wraps to 0
//   cmp_hit    out  NCH            per-channel one-cycle match pulses
//   snap_time  out  TIME_W         captured time value
//   snap_presc out  PRESC_W        captured prescaler value
//   snap_valid out  1              one-cycle pulse when a capture lands
// ============================================================================
module timebase_gen #(
    parameter int PRESC_W = 18,
    parameter int TIME_W  = 32,
    parameter int NCH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESC_W-1:0]    period,
    input  logic [NCH*TIME_W-1:0] cmp_val,
    input  logic [NCH-1:0]        cmp_en,
    input  logic                  snap_req,
    output logic [TIME_W-1:0]     time_o,
    output logic                  tick,
    output logic                  wrap,
    output logic [NCH-1:0]        cmp_hit,
    output logic [TIME_W-1:0]     snap_time,
    output logic [PRESC_W-1:0]    snap_presc,
    output logic                  snap_valid
);

    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_period;
    logic               r_fresh;
    logic [TIME_W-1:0]  r_time;
    logic               r_tick;
    logic               r_wrap;
    logic [NCH-1:0]     r_hit;

    logic [PRESC_W-1:0] w_p_eff;
    logic [PRESC_W-1:0] w_last;
    logic               w_boundary;
    logic [TIME_W-1:0]  w_time_next;
    logic [NCH-1:0]     w_match;

    // Reset leaves the stored period at 0. The first interval after reset
    // uses the period port directly so that the first tick lands exactly P
    // enabled cycles after reset release, even if en is already high.
    assign w_p_eff     = r_fresh ? period : r_period;
    assign w_last      = (w_p_eff == '0) ? '0 : (w_p_eff - PRESC_W'(1));
    // ">=" rather than "==" so a shorter period loaded while disabled can
    // never leave the prescaler stranded above its terminal count.
    assign w_boundary  = (r_presc >= w_last);
    assign w_time_next = r_time + TIME_W'(1);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_cmp
        assign w_match[gi] = cmp_en[gi] &&
                             (cmp_val[gi*TIME_W +: TIME_W] == w_time_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc  <= '0;
            r_period <= '0;
            r_fresh  <= 1'b1;
            r_time   <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
            r_hit    <= '0;
        end else begin
            r_fresh <= 1'b0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_hit   <= '0;
            if (clear) begin
                // Clear beats any tick due this cycle.
                r_presc  <= '0;
                r_time   <= '0;
                r_period <= period;
            end else if (en) begin
                if (w_boundary) begin
                    r_presc  <= '0;
                    r_time   <= w_time_next;
                    r_tick   <= 1'b1;
                    r_wrap   <= (r_time == '1);
                    r_hit    <= w_match;
                    r_period <= period;
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                    if (r_fresh) begin
                        r_period <= period;
                    end
                end
            end else begin
                // Idle: track the period port so a new value is ready on resume.
                r_period <= period;
            end
        end
    end

    assign time_o  = r_time;
    assign tick    = r_tick;
    assign wrap    = r_wrap;
    assign cmp_hit = r_hit;

`ifdef TIMEBASE_SNAPSHOT_EN
    logic [TIME_W-1:0]  r_snap_time;
    logic [PRESC_W-1:0] r_snap_presc;
    logic               r_snap_valid;

    // Captures the pre-edge counter state regardless of en and clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap_time  <= '0;
            r_snap_presc <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap_req;
            if (snap_req) begin
                r_snap_time  <= r_time;
                r_snap_presc <= r_presc;
            end
        end
    end

    assign snap_time  = r_snap_time;
    assign snap_presc = r_snap_presc;
    assign snap_valid = r_snap_valid;
`else
    logic w_snap_unused;
    assign w_snap_unused = snap_req;

    assign snap_time  = '0;
    assign snap_presc = '0;
    assign snap_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timebase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_timebase_gen
// Description : Directed self-checking bench for timebase_gen (TIME_W=4,
//               NCH=4). Each scenario task drives stimulus and compares
//               outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timebase_gen;

    localparam int PRESC_W = 18;
    localparam int TIME_W  = 4;
    localparam int NCH     = 4;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic                  clear;
    logic [PRESC_W-1:0]    period;
    logic [NCH*TIME_W-1:0] cmp_val;
    logic [NCH-1:0]        cmp_en;
    logic                  snap_req;
    logic [TIME_W-1:0]     time_o;
    logic                  tick;
    logic                  wrap;
    logic [NCH-1:0]        cmp_hit;
    logic [TIME_W-1:0]     snap_time;
    logic [PRESC_W-1:0]    snap_presc;
    logic                  snap_valid;

    int total;
    int bad;

    timebase_gen #(
        .PRESC_W(PRESC_W),
        .TIME_W (TIME_W),
        .NCH    (NCH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clear     (clear),
        .period    (period),
        .cmp_val   (cmp_val),
        .cmp_en    (cmp_en),
        .snap_req  (snap_req),
        .time_o    (time_o),
        .tick      (tick),
        .wrap      (wrap),
        .cmp_hit   (cmp_hit),
        .snap_time (snap_time),
        .snap_presc(snap_presc),
        .snap_valid(snap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge with the given setup, then release.
    task automatic do_reset(input logic [PRESC_W-1:0] p, input logic e);
        rst      = 1'b0;
        en       = e;
        clear    = 1'b0;
        period   = p;
        snap_req = 1'b0;
        #1;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        cmp_val = '0;
        cmp_en  = '0;
        do_reset(18'd4, 1'b0);
        total++;
        if (time_o !== 4'd0 || tick !== 1'b0 || wrap !== 1'b0 || cmp_hit !== 4'd0) begin
            bad++;
            $display("FAIL reset_outputs time=%0d tick=%b wrap=%b hit=%b want 0/0/0/0000",
                     time_o, tick, wrap, cmp_hit);
        end
        total++;
        if (snap_time !== 4'd0 || snap_presc !== 18'd0 || snap_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_snap time=%0d presc=%0d valid=%b want 0/0/0",
                     snap_time, snap_presc, snap_valid);
        end
    endtask

    // period=4: ticks on enabled cycles 4, 8, 12 with time 1, 2, 3.
    task automatic test_basic();
        do_reset(18'd4, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            total++;
            if (tick !== ((k % 4) == 0) || time_o !== 4'(k / 4)) begin
                bad++;
                $display("FAIL basic cyc=%0d tick=%b time=%0d want tick=%b time=%0d",
                         k, tick, time_o, ((k % 4) == 0), k / 4);
            end
        end
    endtask

    task automatic test_period0();
        do_reset(18'd0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step();
            total++;
            if (tick !== 1'b1 || time_o !== 4'(k)) begin
                bad++;
                $display("FAIL period0 cyc=%0d tick=%b time=%0d want tick=1 time=%0d",
                         k, tick, time_o, k);
            end
        end
    endtask

    // period 10 -> 3 during the first interval: ticks at 10, 13, 16.
    task automatic test_period_change();
        logic exp_t;
        int   exp_time;
        do_reset(18'd10, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) period = 18'd3;
            step();
            exp_t    = (k == 10) || (k == 13) || (k == 16);
            exp_time = (k >= 16) ? 3 : (k >= 13) ? 2 : (k >= 10) ? 1 : 0;
            total++;
            if (tick !== exp_t || time_o !== 4'(exp_time)) begin
                bad++;
                $display("FAIL period_change cyc=%0d tick=%b time=%0d want tick=%b time=%0d",
                         k, tick, time_o, exp_t, exp_time);
            end
        end
    endtask

    // period=1: 16 ticks take time 15 -> 0 with wrap on that tick only.
    task automatic test_wrap();
        do_reset(18'd1, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            step();
            total++;
            if (tick !== 1'b1 || wrap !== (k == 16) || time_o !== 4'(k % 16)) begin
                bad++;
                $display("FAIL wrap cyc=%0d tick=%b wrap=%b time=%0d want 1/%b/%0d",
                         k, tick, wrap, time_o, (k == 16), k % 16);
            end
        end
    endtask

    // ch0=ch1=ch2=5, ch3=7, only ch0 and ch2 enabled, period=2.
    task automatic test_compare();
        cmp_val = 16'h7555;
        cmp_en  = 4'b0101;
        do_reset(18'd2, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            step();
            total++;
            if (cmp_hit !== ((k == 10) ? 4'b0101 : 4'b0000) || tick !== ((k % 2) == 0)) begin
                bad++;
                $display("FAIL compare cyc=%0d hit=%b tick=%b want hit=%b tick=%b",
                         k, cmp_hit, tick, ((k == 10) ? 4'b0101 : 4'b0000), ((k % 2) == 0));
            end
        end
        // time_o is now 7; retarget ch0 to 7 with no tick: must not hit.
        en      = 1'b0;
        cmp_val = 16'h7557;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (cmp_hit !== 4'b0000 || time_o !== 4'd7) begin
                bad++;
                $display("FAIL compare_no_tick hit=%b time=%0d want 0000 time=7", cmp_hit, time_o);
            end
        end
        cmp_en = '0;
    endtask

    task automatic test_clear_freeze();
        logic exp_t;
        do_reset(18'd3, 1'b1);
        for (int k = 1; k <= 5; k++) step();
        // Cycle 6 would tick; clear wins.
        clear = 1'b1;
        step();
        clear = 1'b0;
        total++;
        if (time_o !== 4'd0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL clear_vs_tick time=%0d tick=%b want 0/0", time_o, tick);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            total++;
            if (tick !== (k == 3) || time_o !== 4'((k == 3) ? 1 : 0)) begin
                bad++;
                $display("FAIL after_clear cyc=%0d tick=%b time=%0d", k, tick, time_o);
            end
        end
        step();                 // presc now 1
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            total++;
            if (tick !== 1'b0 || time_o !== 4'd1) begin
                bad++;
                $display("FAIL freeze cyc=%0d tick=%b time=%0d want 0/1", k, tick, time_o);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            step();
            exp_t = (k == 2);
            total++;
            if (tick !== exp_t || time_o !== 4'((k == 2) ? 2 : 1)) begin
                bad++;
                $display("FAIL resume cyc=%0d tick=%b time=%0d want %b/%0d",
                         k, tick, time_o, exp_t, (k == 2) ? 2 : 1);
            end
        end
    endtask

    task automatic test_snapshot_and_reset();
        logic [TIME_W-1:0]  exp_st;
        logic [PRESC_W-1:0] exp_sp;
        logic               exp_sv;
        do_reset(18'd4, 1'b1);
        for (int k = 1; k <= 14; k++) step();   // time=3, presc=2
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
`ifdef TIMEBASE_SNAPSHOT_EN
        exp_st = 4'd3;
        exp_sp = 18'd2;
        exp_sv = 1'b1;
`else
        exp_st = 4'd0;
        exp_sp = 18'd0;
        exp_sv = 1'b0;
`endif
        total++;
        if (snap_valid !== exp_sv || snap_time !== exp_st || snap_presc !== exp_sp) begin
            bad++;
            $display("FAIL snapshot valid=%b time=%0d presc=%0d want %b/%0d/%0d",
                     snap_valid, snap_time, snap_presc, exp_sv, exp_st, exp_sp);
        end
        step();                 // cycle 16: tick, time=4
        total++;
        if (snap_valid !== 1'b0 || snap_time !== exp_st || tick !== 1'b1 || time_o !== 4'd4) begin
            bad++;
            $display("FAIL snapshot_hold valid=%b stime=%0d tick=%b time=%0d want 0/%0d/1/4",
                     snap_valid, snap_time, tick, time_o, exp_st);
        end
        // Asynchronous reset mid-operation clears outputs without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (time_o !== 4'd0 || tick !== 1'b0 || wrap !== 1'b0 || cmp_hit !== 4'd0 ||
            snap_time !== 4'd0 || snap_presc !== 18'd0 || snap_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset time=%0d tick=%b wrap=%b hit=%b st=%0d sp=%0d sv=%b want all 0",
                     time_o, tick, wrap, cmp_hit, snap_time, snap_presc, snap_valid);
        end
        step();
        rst = 1'b1;
        // Counting restarts from presc=0: first tick after 4 enabled cycles.
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if (tick !== (k == 4) || time_o !== 4'((k == 4) ? 1 : 0)) begin
                bad++;
                $display("FAIL restart cyc=%0d tick=%b time=%0d", k, tick, time_o);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        en       = 1'b0;
        clear    = 1'b0;
        period   = '0;
        cmp_val  = '0;
        cmp_en   = '0;
        snap_req = 1'b0;
        test_reset();
        test_basic();
        test_period0();
        test_period_change();
        test_wrap();
        test_compare();
        test_clear_freeze();
        test_snapshot_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timebase_gen.md
TIMEBASE_GEN -- requirements
Module: timebase_gen

Interface
REQ-001 SHALL have parameter PRESC_W, default 18, prescaler and period width.
REQ-002 SHALL have parameter TIME_W, default 32, time counter width.
REQ-003 SHALL have parameter NCH, default 4, compare channel count (1..16).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  count enable; low freezes prescaler and time.
REQ-007 SHALL have port clear  input  1  synchronous clear of prescaler and time.
REQ-008 SHALL have port period  input  PRESC_W  clocks per tick.
REQ-009 SHALL have port cmp_val  input  NCH*TIME_W  compare values; channel i at bits [i*TIME_W +: TIME_W].
REQ-010 SHALL have port cmp_en  input  NCH  per-channel compare enable.
REQ-011 SHALL have port snap_req  input  1  snapshot strobe.
REQ-012 SHALL have port time_o  output  TIME_W  elapsed tick count.
REQ-013 SHALL have port tick  output  1  one-cycle pulse per tick.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse when time_o wraps to 0.
REQ-015 SHALL have port cmp_hit  output  NCH  per-channel one-cycle match pulses.
REQ-016 SHALL have ports snap_time (TIME_W), snap_presc (PRESC_W), snap_valid (1), all outputs.

Function
REQ-017 SHALL keep an internal prescaler presc counting 0..P-1, where P is the active period; P=0 SHALL act as P=1 (tick every enabled cycle).
REQ-018 SHALL, when en=1 and presc==P-1, set presc to 0, increment time_o and assert tick in the same registered cycle that time_o updates.
REQ-019 SHALL load the active period from the period port only when en=0, on a tick, or on clear; mid-tick changes take effect at the next tick boundary.
REQ-020 SHALL wrap time_o from 2^TIME_W-1 to 0 on a tick and assert wrap together with that tick.
REQ-021 SHALL give clear priority over a tick: presc=0, time_o=0, no tick/wrap/cmp_hit that cycle.
REQ-022 SHALL, when en=0, hold presc and time_o and emit no tick, wrap or cmp_hit.
REQ-023 SHALL assert cmp_hit[i] for one cycle, coincident with tick, when cmp_en[i]=1 and the new time_o equals channel i's cmp_val; several channels MAY hit in the same cycle.
REQ-024 SHALL NOT assert cmp_hit from a cmp_val change alone, without a tick.
REQ-025 SHALL deliver the first tick after reset exactly P enabled cycles after rst deassertion.

Reset
REQ-026 SHALL, on rst=0, asynchronously set presc=0, time_o=0, tick=0, wrap=0, cmp_hit=0, snap_time=0, snap_presc=0, snap_valid=0, and active period=0.
REQ-027 SHALL abort any partial tick interval on reset mid-operation; counting restarts from presc=0.

Configuration
REQ-028 SHALL compile snapshot logic only when macro TIMEBASE_SNAPSHOT_EN is defined.
REQ-029 SHALL, with TIMEBASE_SNAPSHOT_EN, on snap_req=1 register the pre-edge time_o and presc into snap_time/snap_presc and pulse snap_valid for one cycle at the next edge; capture SHALL work regardless of en and clear.
REQ-030 SHALL, without TIMEBASE_SNAPSHOT_EN, keep all snapshot ports present, drive snap_time, snap_presc and snap_valid constant 0, and ignore snap_req.

Verification
REQ-031 SHALL cover: period=4, en=1 after reset -> tick on enabled cycles 4, 8, 12; time_o=1, 2, 3.
REQ-032 SHALL cover: period=0 -> tick every cycle; period changed 10->3 mid-interval -> current interval stays 10, following intervals 3.
REQ-033 SHALL cover: TIME_W=4, period=1, 16 ticks -> time_o 15->0 with wrap and tick in the same cycle.
REQ-034 SHALL cover: cmp_val ch0=5, ch2=5, cmp_en=4'b0101 -> cmp_hit=4'b0101 exactly at the tick setting time_o=5; ch1 disabled -> never hits.
REQ-035 SHALL cover: clear and a tick in the same cycle -> time_o=0, no tick; en=0 for 7 cycles -> presc and time_o frozen.
REQ-036 SHALL cover: snap_req at time_o=3, presc=2 with macro -> snap_valid pulse, snap_time=3, snap_presc=2; without macro -> all snapshot outputs 0; rst asserted mid-interval -> all outputs 0 immediately.
